membus: RTL and testbench

MEMBUS -- requirements
Module: membus

---
 rtl/membus.sv | 179 +++++++++++++++++
 tb/tb_membus.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/membus.sv
// membus: CPU bus responder. Decodes each CPU access into internal RAM,
// an external IO register window, an external ROM, or open bus, and
// releases the CPU with a one-cycle locked pulse once the access completes.
//
// Memory map (decode uses address bits only, no arithmetic):
//   0000-1FFF  2 KB internal RAM, indexed by address[10:0], mirrored x4
//   2000-3FFF  IO window, io_addr = address[2:0], mirrored every 8 bytes
//   4000-7FFF  open bus (returns the last value seen on the data bus)
//   8000-FFFF  ROM, ext_addr = address[14:0], read-only
module membus #(
  parameter int unsigned EXT_WAIT   = 2,   // extra ROM wait cycles, 0..15
  parameter int unsigned IO_TIMEOUT = 15   // IO cycles before giving up, 1..15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  o_data,
  input  logic        we,
  output logic [7:0]  i_data,
  output logic        locked,
  output logic [14:0] ext_addr,
  input  logic [7:0]  ext_rdata,
  output logic [2:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_we,
  output logic        io_req,
  input  logic        io_ack,
  input  logic [7:0]  io_rdata
);

  typedef enum logic [1:0] {
    S_ACCEPT,
    S_WAIT,
    S_IOWAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_OPEN,
    REG_ROM
  } region_t;

  // Wait-counter reload for ROM and the last IOWAIT count before timeout.
  localparam logic [3:0] EXT_WAIT_L = 4'(EXT_WAIT);
  localparam logic [3:0] IO_LAST    = 4'(IO_TIMEOUT - 1);

  // Region decode by truncation: only the top address bits are inspected.
  function automatic region_t decode(input logic [15:0] a);
    if (a[15])      return REG_ROM;
    else if (a[14]) return REG_OPEN;
    else if (a[13]) return REG_IO;
    else            return REG_RAM;
  endfunction

  state_t      state;
  state_t      state_next;
  region_t     acc_region;   // region of the live address, used in ACCEPT
  region_t     region_q;     // region captured at ACCEPT
  logic [14:0] addr_q;       // captured address (bit 15 lives in region_q)
  logic        we_q;
  logic [7:0]  wdata_q;
  logic [3:0]  wait_cnt;     // remaining WAIT cycles after the current one
  logic [3:0]  io_cnt;       // IOWAIT cycles already completed
  logic [7:0]  open_bus;     // last value seen on the data bus
  logic [7:0]  resp_data;    // value i_data takes when entering RESP
  logic        ram_we;
  logic [7:0]  ram_q;
  logic [7:0]  ram [0:2047];

  assign acc_region = decode(address);
  assign ext_addr   = addr_q;
  assign io_addr    = addr_q[2:0];
  assign io_wdata   = wdata_q;

  // The RAM write happens on the edge that ends ACCEPT; a reset at that
  // edge suppresses it so an aborted access never modifies memory.
  assign ram_we = resetn && (state == S_ACCEPT) && (acc_region == REG_RAM) && we;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!resetn) state <= S_ACCEPT;
    else         state <= state_next;
  end

  // Next-state decision and the data that will be presented in RESP.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_next = state;
    resp_data  = open_bus;
    unique case (state)
      S_ACCEPT: begin
        unique case (acc_region)
          REG_RAM:  state_next = S_WAIT;
          REG_IO:   state_next = S_IOWAIT;
          REG_OPEN: state_next = S_RESP;
          REG_ROM:  state_next = we ? S_RESP : S_WAIT;
        endcase
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_next = S_RESP;
        if (region_q == REG_ROM) resp_data = ext_rdata;
        else                     resp_data = we_q ? wdata_q : ram_q;
      end
      S_IOWAIT: begin
        // An ack in the timeout cycle is checked first, so the ack wins.
        if (io_ack) begin
          state_next = S_RESP;
          resp_data  = we_q ? wdata_q : io_rdata;
        end else if (io_cnt == IO_LAST) begin
          state_next = S_RESP;
        end
      end
      S_RESP: state_next = S_ACCEPT;
    endcase
  end

  // Access capture, counters, IO handshake and registered CPU outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      locked   <= 1'b0;
      i_data   <= 8'h00;
      open_bus <= 8'h00;
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      wait_cnt <= 4'd0;
      io_cnt   <= 4'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 8'h00;
      region_q <= REG_RAM;
    end else begin
      locked <= (state_next == S_RESP);
      if (state_next == S_RESP) i_data <= resp_data;

      unique case (state)
        S_ACCEPT: begin
          addr_q   <= address[14:0];
          we_q     <= we;
          wdata_q  <= o_data;
          region_q <= acc_region;
          wait_cnt <= (acc_region == REG_ROM) ? EXT_WAIT_L : 4'd0;
          io_cnt   <= 4'd0;
          io_req   <= (acc_region == REG_IO);
          io_we    <= (acc_region == REG_IO) && we;
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        S_IOWAIT: begin
          if (state_next == S_RESP) begin
            io_req <= 1'b0;
            io_we  <= 1'b0;
          end else begin
            io_cnt <= io_cnt + 4'd1;
          end
        end
        S_RESP: begin
          // The bus last carried the CPU's byte on a write, else i_data.
          open_bus <= we_q ? wdata_q : i_data;
        end
      endcase
    end
  end

  // Internal RAM: write at the end of ACCEPT, registered read captured there
  // too so the data is ready during WAIT.
  always_ff @(posedge clock) begin
    // NOTE: the RAM array and its read register are deliberately not reset;
    // contents survive reset and the array can map onto block RAM.
    if (ram_we) ram[address[10:0]] <= o_data;
    if (state == S_ACCEPT) ram_q <= ram[address[10:0]];
  end

endmodule

// File: tb/tb_membus.sv
// tb_membus: directed and randomized CPU accesses against membus, checked
// against a region/latency/data model of the bus written from the memory map.
module tb_membus;

  localparam int EXT_WAIT   = 2;
  localparam int IO_TIMEOUT = 15;
  localparam int MAX_LAT    = 40;

  logic        clock    = 1'b0;
  logic        resetn   = 1'b0;
  logic [15:0] address  = 16'h0000;
  logic [7:0]  o_data   = 8'h00;
  logic        we       = 1'b0;
  logic [7:0]  i_data;
  logic        locked;
  logic [14:0] ext_addr;
  logic [7:0]  ext_rdata;
  logic [2:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic        io_req;
  logic        io_ack   = 1'b0;
  logic [7:0]  io_rdata = 8'h00;

  int tests = 0;
  int fails = 0;

  // Reference state: RAM image, list of written RAM indices, bus latch.
  logic [7:0] ram_m [2048];
  int         written_q [$];
  logic [7:0] open_bus_m = 8'h00;

  // ROM content model: byte at offset 0 is A9.
  function automatic logic [7:0] rom_byte(input logic [14:0] a);
    return 8'hA9 ^ a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  assign ext_rdata = rom_byte(ext_addr);

  always #20 clock = ~clock;

  membus #(
    .EXT_WAIT  (EXT_WAIT),
    .IO_TIMEOUT(IO_TIMEOUT)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .address  (address),
    .o_data   (o_data),
    .we       (we),
    .i_data   (i_data),
    .locked   (locked),
    .ext_addr (ext_addr),
    .ext_rdata(ext_rdata),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_we    (io_we),
    .io_req   (io_req),
    .io_ack   (io_ack),
    .io_rdata (io_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete access. Called while the DUT is in ACCEPT (#1 after the
  // edge); returns #1 after the edge that starts the following ACCEPT.
  // ack_after: IOWAIT cycle in which io_ack is raised (> IO_TIMEOUT = never).
  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input int ack_after, input logic [7:0] rd);
    int         exp_lat;
    int         exp_io;
    int         lat;
    int         io_cyc;
    logic [7:0] exp_data;
    bit         is_io;
    bit         got;

    is_io  = 1'b0;
    exp_io = 0;
    if (a < 16'h2000) begin
      exp_lat  = 2;
      exp_data = w ? d : ram_m[a[10:0]];
    end else if (a < 16'h4000) begin
      is_io = 1'b1;
      if (ack_after <= IO_TIMEOUT) begin
        exp_lat  = ack_after + 1;
        exp_io   = ack_after;
        exp_data = w ? d : rd;
      end else begin
        exp_lat  = IO_TIMEOUT + 1;
        exp_io   = IO_TIMEOUT;
        exp_data = open_bus_m;
      end
    end else if (a < 16'h8000 || w) begin
      exp_lat  = 1;
      exp_data = open_bus_m;
    end else begin
      exp_lat  = EXT_WAIT + 2;
      exp_data = rom_byte(a[14:0]);
    end

    address  = a;
    we       = w;
    o_data   = d;
    io_rdata = rd;
    io_ack   = is_io ? 1'b0 : 1'($urandom_range(0, 1));
    lat      = 0;
    io_cyc   = 0;
    got      = 1'b0;
    while (!got && lat < MAX_LAT) begin
      @(posedge clock);
      #1;
      lat++;
      if (locked) begin
        got = 1'b1;
      end else if (io_req) begin
        io_cyc++;
        check("io_addr_we", 32'({io_addr, io_we}), 32'({a[2:0], w}));
        if (w) check("io_wdata", 32'(io_wdata), 32'(d));
      end
      if (is_io) io_ack = io_req && (io_cyc == ack_after);
      else       io_ack = 1'($urandom_range(0, 1));
    end
    check("locked_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("i_data", 32'(i_data), 32'(exp_data));
    if (is_io) check("io_req_cycles", 32'(io_cyc), 32'(exp_io));

    if (a < 16'h2000 && w) begin
      ram_m[a[10:0]] = d;
      written_q.push_back(int'(a[10:0]));
    end
    open_bus_m = w ? d : exp_data;

    @(posedge clock);
    #1;
    check("single_pulse", 32'({locked, io_req}), 32'd0);
    io_ack = 1'b0;
  endtask

  // Start a read at a, let it run cycles_in cycles, then reset for one edge.
  task automatic reset_mid(input logic [15:0] a, input int cycles_in);
    address = a;
    we      = 1'b0;
    o_data  = 8'hEE;
    io_ack  = 1'b0;
    repeat (cycles_in) begin
      @(posedge clock);
      #1;
    end
    check("pre_rst_locked", 32'(locked), 32'd0);
    if (a >= 16'h2000 && a < 16'h4000) check("pre_rst_io_req", 32'(io_req), 32'd1);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_i_data", 32'(i_data), 32'd0);
    check("rst_io", 32'({io_req, io_we}), 32'd0);
    resetn     = 1'b1;
    open_bus_m = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    int          r;
    int          ack;

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_i_data", 32'(i_data), 32'd0);
    check("reset_io", 32'({io_req, io_we}), 32'd0);
    resetn = 1'b1;

    // RAM write then mirrored read.
    access(16'h0012, 1'b1, 8'h5A, 0, 8'h00);
    access(16'h0812, 1'b0, 8'h00, 0, 8'h00);
    // ROM read with EXT_WAIT=2.
    access(16'h8000, 1'b0, 8'h00, 0, 8'h00);
    // IO read acked in the third cycle.
    access(16'h2002, 1'b0, 8'h00, 3, 8'h80);
    // IO read never acked: timeout, returns the previous bus value.
    access(16'h2007, 1'b0, 8'h00, 99, 8'h11);
    // ROM write then open-bus read.
    access(16'h8000, 1'b1, 8'h33, 0, 8'h00);
    access(16'h5000, 1'b0, 8'h00, 0, 8'h00);
    // IO write acked exactly in the timeout cycle: the ack wins.
    access(16'h3FFB, 1'b1, 8'h4C, IO_TIMEOUT, 8'h22);
    // IO write acked in the first cycle.
    access(16'h2001, 1'b1, 8'hC3, 1, 8'h99);

    // Reset during ROM WAIT, then the next access starts immediately.
    reset_mid(16'h8123, 2);
    access(16'h5000, 1'b0, 8'h00, 0, 8'h00);
    // Reset during IOWAIT drops io_req; RAM contents survive.
    reset_mid(16'h2005, 3);
    access(16'h1012, 1'b0, 8'h00, 0, 8'h00);

    // Randomized accesses across all regions.
    for (int n = 0; n < 80; n++) begin
      r   = $urandom_range(0, 3);
      w   = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      ack = $urandom_range(1, IO_TIMEOUT + 2);
      case (r)
        0: begin
          if (w) a = {3'b000, 13'($urandom)};
          else   a = {3'b000, 2'($urandom), 11'(written_q[$urandom_range(0, written_q.size() - 1)])};
        end
        1:       a = {3'b001, 13'($urandom)};
        2:       a = {2'b01, 14'($urandom)};
        default: a = {1'b1, 15'($urandom)};
      endcase
      access(a, w, d, ack, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
